// File: rtl/divide16_ctrl.sv
// Sequencing controller for the two-stage radix-16 SRT divider: accepts a
// fractional divide request, steps the datapath and assembles the quotient.
module divide16_ctrl #(
  parameter int unsigned ITER = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        dividend,
  input  logic [7:0]        divisor,
  output logic              busy,
  output logic              done,
  output logic [4*ITER-1:0] quotient,
  output logic              err,
  output logic [7:0]        dp_op1,
  output logic [7:0]        dp_op2,
  output logic              dp_state0,
  input  logic [3:0]        dp_qj,
  input  logic [3:0]        dp_qjn,
  input  logic [10:0]       dp_sum2,
  input  logic [10:0]       dp_carry2
);

  localparam int unsigned QW = 4 * ITER;
  localparam int unsigned CW = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ITER, S_CORR, S_DONE} state_t;

  state_t        state;
  logic [QW-1:0] qp;
  logic [QW-1:0] qn;
  logic [CW-1:0] cnt;
  logic [10:0]   rem_sum;
  logic          rem_neg;
  logic          range_bad;

  // Sign of the redundant residual decides the final -1 correction.
  assign rem_sum   = dp_sum2 + dp_carry2;
  assign rem_neg   = rem_sum[10];
  // Quotient must be a proper fraction with a normalized divisor.
  assign range_bad = !divisor[7] || (dividend >= divisor);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      qp        <= '0;
      qn        <= '0;
      cnt       <= '0;
      quotient  <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dp_state0 <= 1'b0;
      dp_op1    <= '0;
      dp_op2    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            dp_op1 <= dividend;
            dp_op2 <= divisor;
            if (range_bad) begin
              err      <= 1'b1;
              quotient <= '1;
              done     <= 1'b1;
              state    <= S_DONE;
            end else begin
              qp        <= '0;
              qn        <= '0;
              err       <= 1'b0;
              busy      <= 1'b1;
              dp_state0 <= 1'b1;
              state     <= S_LOAD;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_LOAD: begin
          dp_state0 <= 1'b0;
          cnt       <= CW'(ITER - 1);
          state     <= S_ITER;
        end
        S_ITER: begin
          // Digits arrive most significant first.
          qp <= (qp << 4) | QW'(dp_qj);
          qn <= (qn << 4) | QW'(dp_qjn);
          if (cnt == '0) begin
            state <= S_CORR;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_CORR: begin
          quotient <= qp - qn - QW'(rem_neg);
          busy     <= 1'b0;
          done     <= 1'b1;
          state    <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divide16_ctrl.sv
// Bench for divide16_ctrl: a digit-level stand-in for the divider plus a
// result scoreboard checked on every done pulse.
module tb_divide16_ctrl;

  localparam int unsigned ITER = 2;

  logic        clock;
  logic        reset;
  logic        start;
  logic [7:0]  dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [7:0]  quotient;
  logic        err;
  logic [7:0]  dp_op1;
  logic [7:0]  dp_op2;
  logic        dp_state0;
  logic [3:0]  dp_qj;
  logic [3:0]  dp_qjn;
  logic [10:0] dp_sum2;
  logic [10:0] dp_carry2;

  int errors;
  int checks;
  int done_seen;
  logic [8:0] exp_q[$];

  logic [7:0]  plan_qp;
  logic [7:0]  plan_qn;
  logic [10:0] plan_sum;
  logic [10:0] plan_carry;

  divide16_ctrl #(.ITER(ITER)) dut (
    .clock(clock), .reset(reset), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .err(err),
    .dp_op1(dp_op1), .dp_op2(dp_op2), .dp_state0(dp_state0),
    .dp_qj(dp_qj), .dp_qjn(dp_qjn), .dp_sum2(dp_sum2), .dp_carry2(dp_carry2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Divider stand-in: after a state0 cycle, present planned digits MS first.
  initial begin : dp_model
    int di;
    di = 0;
    dp_qj = '0; dp_qjn = '0; dp_sum2 = '0; dp_carry2 = '0;
    forever begin
      @(posedge clock); #1;
      if (reset) di = 0;
      else if (dp_state0) di = ITER;
      else if (di > 0) begin
        dp_qj     = plan_qp[4*(di-1) +: 4];
        dp_qjn    = plan_qn[4*(di-1) +: 4];
        dp_sum2   = plan_sum;
        dp_carry2 = plan_carry;
        di--;
      end
    end
  end

  initial begin : scoreboard
    logic [8:0] e;
    forever begin
      @(negedge clock);
      if (done === 1'b1) begin
        done_seen++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: got err=%b q=%h, required no done pulse", err, quotient);
        end else begin
          e = exp_q.pop_front();
          if ({err, quotient} !== e) begin
            errors++;
            $display("FAIL result: got err=%b q=%h, required err=%b q=%h", err, quotient, e[8], e[7:0]);
          end
        end
      end
    end
  end

  function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b);
    if (!b[7] || a >= b) return {1'b1, 8'hFF};
    return {1'b0, 8'((32'(a) << 8) / 32'(b))};
  endfunction

  // Redundant digit plan: Qp - Qn equals q or q+1, the latter with negative residual.
  task automatic set_plan(input logic [7:0] a, input logic [7:0] b, input logic use_force,
                          input logic [7:0] fqp, input logic [7:0] fqn, input logic fneg);
    logic [7:0]  q;
    logic [7:0]  target;
    int unsigned r;
    logic        neg;
    logic [10:0] v;
    if (use_force) begin
      plan_qp = fqp;
      plan_qn = fqn;
      neg     = fneg;
    end else begin
      q      = 8'((32'(a) << 8) / 32'(b));
      r      = (32'(a) << 8) - 32'(q) * 32'(b);
      neg    = (r != 0) && ($urandom_range(0, 1) == 1);
      target = neg ? q + 8'd1 : q;
      plan_qn = 8'($urandom);
      plan_qp = target + plan_qn;
    end
    v          = {neg, 10'($urandom)};
    plan_sum   = 11'($urandom);
    plan_carry = v - plan_sum;
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic use_force,
                        input logic [7:0] fqp, input logic [7:0] fqn, input logic fneg,
                        input logic [8:0] expv, output int lat, output int st0,
                        output int bsy, output int opbad);
    set_plan(a, b, use_force, fqp, fqn, fneg);
    @(negedge clock);
    dividend = a; divisor = b; start = 1'b1;
    exp_q.push_back(expv);
    @(posedge clock); #1;
    start = 1'b0;
    lat = 1; st0 = 0; bsy = 0; opbad = 0;
    while (done !== 1'b1 && lat < 20) begin
      st0 += int'(dp_state0);
      bsy += int'(busy);
      if (dp_op1 !== a || dp_op2 !== b) opbad++;
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clock);
    start = 1'b1; dividend = 8'h40; divisor = 8'h80;
    @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b, required 0", err); end
    checks++; if (quotient !== 8'h00) begin errors++; $display("FAIL reset_q: got %h, required 00", quotient); end
    checks++; if (dp_state0 !== 1'b0) begin errors++; $display("FAIL reset_state0: got %b, required 0", dp_state0); end
    checks++; if (dp_op1 !== 8'h00 || dp_op2 !== 8'h00) begin
      errors++; $display("FAIL reset_ops: got %h/%h, required 00/00", dp_op1, dp_op2);
    end
    start = 1'b0; reset = 1'b0;
    @(posedge clock); #1;
    checks++; if (busy !== 1'b0 || dp_state0 !== 1'b0) begin
      errors++; $display("FAIL reset_start_ignored: got busy=%b state0=%b, required 0/0", busy, dp_state0);
    end
  endtask

  task automatic test_normal();
    int lat, st0, bsy, opbad;
    run_op(8'hAF, 8'hC5, 1'b0, 8'h00, 8'h00, 1'b0, {1'b0, 8'hE3}, lat, st0, bsy, opbad);
    checks++; if (lat != 5) begin errors++; $display("FAIL normal_latency: got %0d, required 5", lat); end
    checks++; if (st0 != 1) begin errors++; $display("FAIL normal_state0_cycles: got %0d, required 1", st0); end
    checks++; if (bsy != 4) begin errors++; $display("FAIL normal_busy_cycles: got %0d, required 4", bsy); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL normal_busy_at_done: got %b, required 0", busy); end
    checks++; if (opbad != 0) begin errors++; $display("FAIL normal_ops_stable: got %0d bad cycles, required 0", opbad); end
  endtask

  task automatic test_exact();
    int lat, st0, bsy, opbad;
    run_op(8'h93, 8'hC0, 1'b0, 8'h00, 8'h00, 1'b0, {1'b0, 8'hC4}, lat, st0, bsy, opbad);
    checks++; if (lat != 5) begin errors++; $display("FAIL exact1_latency: got %0d, required 5", lat); end
    run_op(8'h60, 8'hC0, 1'b0, 8'h00, 8'h00, 1'b0, {1'b0, 8'h80}, lat, st0, bsy, opbad);
    checks++; if (lat != 5) begin errors++; $display("FAIL exact2_latency: got %0d, required 5", lat); end
  endtask

  task automatic test_range_err();
    int lat, st0, bsy, opbad;
    run_op(8'h80, 8'h80, 1'b0, 8'h00, 8'h00, 1'b0, {1'b1, 8'hFF}, lat, st0, bsy, opbad);
    checks++; if (lat != 1) begin errors++; $display("FAIL err_ge_latency: got %0d, required 1", lat); end
    checks++; if (st0 != 0 || dp_state0 !== 1'b0) begin
      errors++; $display("FAIL err_ge_state0: got %0d cycles, required 0", st0);
    end
    run_op(8'h10, 8'h40, 1'b0, 8'h00, 8'h00, 1'b0, {1'b1, 8'hFF}, lat, st0, bsy, opbad);
    checks++; if (lat != 1) begin errors++; $display("FAIL err_unnorm_latency: got %0d, required 1", lat); end
    checks++; if (st0 != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL err_unnorm_state0: got %0d cycles busy=%b, required 0/0", st0, busy);
    end
  endtask

  task automatic test_random();
    int lat, st0, bsy, opbad;
    logic [7:0] a, b;
    for (int i = 0; i < 4; i++) begin
      b = 8'h80 | 8'($urandom);
      a = 8'($urandom_range(0, int'(b) - 1));
      run_op(a, b, 1'b0, 8'h00, 8'h00, 1'b0, model(a, b), lat, st0, bsy, opbad);
      checks++; if (lat != 5) begin errors++; $display("FAIL random_latency[%0d]: got %0d, required 5", i, lat); end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int times[3];
    set_plan(8'hAF, 8'hC5, 1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge clock);
    dividend = 8'hAF; divisor = 8'hC5; start = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, 8'hE3});
    n = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clock); #1;
      if (done === 1'b1) begin
        if (n < 3) times[n] = c;
        n++;
      end
      if (c == 12) start = 1'b0;
    end
    checks++; if (n != 3) begin errors++; $display("FAIL b2b_count: got %0d, required 3", n); end
    else begin
      checks++; if (times[0] != 5 || times[1] != 10 || times[2] != 15) begin
        errors++; $display("FAIL b2b_spacing: got %0d,%0d,%0d, required 5,10,15", times[0], times[1], times[2]);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    int seen, lat, st0, bsy, opbad;
    set_plan(8'hAF, 8'hC5, 1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge clock);
    dividend = 8'hAF; divisor = 8'hC5; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b, required 1", busy); end
    reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL midrst_flags: got busy=%b done=%b err=%b, required 0/0/0", busy, done, err);
    end
    checks++; if (quotient !== 8'h00 || dp_state0 !== 1'b0) begin
      errors++; $display("FAIL midrst_q: got q=%h state0=%b, required 00/0", quotient, dp_state0);
    end
    checks++; if (dp_op1 !== 8'h00 || dp_op2 !== 8'h00) begin
      errors++; $display("FAIL midrst_ops: got %h/%h, required 00/00", dp_op1, dp_op2);
    end
    seen = done_seen;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (8) @(posedge clock);
    checks++; if (done_seen != seen) begin
      errors++; $display("FAIL midrst_no_done: got %0d pulses, required 0", done_seen - seen);
    end
    run_op(8'h93, 8'hC0, 1'b0, 8'h00, 8'h00, 1'b0, {1'b0, 8'hC4}, lat, st0, bsy, opbad);
    checks++; if (lat != 5) begin errors++; $display("FAIL midrst_next_latency: got %0d, required 5", lat); end
  endtask

  task automatic test_digit_model();
    int lat, st0, bsy, opbad;
    run_op(8'hAF, 8'hC5, 1'b1, 8'hF0, 8'h0F, 1'b0, {1'b0, 8'hE1}, lat, st0, bsy, opbad);
    checks++; if (lat != 5) begin errors++; $display("FAIL digits_pos_latency: got %0d, required 5", lat); end
    run_op(8'hAF, 8'hC5, 1'b1, 8'hF0, 8'h0F, 1'b1, {1'b0, 8'hE0}, lat, st0, bsy, opbad);
    checks++; if (lat != 5) begin errors++; $display("FAIL digits_neg_latency: got %0d, required 5", lat); end
  endtask

  initial begin
    errors = 0; checks = 0; done_seen = 0;
    plan_qp = '0; plan_qn = '0; plan_sum = '0; plan_carry = '0;
    test_reset();
    test_normal();
    test_exact();
    test_range_err();
    test_random();
    test_back_to_back();
    test_reset_mid_op();
    test_digit_model();
    repeat (3) @(negedge clock);
    checks++; if (exp_q.size() != 0) begin
      errors++; $display("FAIL drain: got %0d results outstanding, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/divide16_ctrl.md
# divide16_ctrl

Sequencing controller for the two-stage radix-16 SRT divider datapath (`divide16`). It accepts an 8-bit fractional divide request over a start/done handshake and drives the divider's operand and `state0` load inputs. Each iteration it collects the redundant quotient digits (`qj`/`qjn`) and converts them to a binary quotient. A final correction step uses the sign of the redundant partial remainder. It sits between the request source and `divide16`, and is the only block that drives the divider's control inputs.

## Interface
- ITER, 2, number of radix-16 iterations; quotient width is 4*ITER.
- clock  in  1  system clock; the divider shares this clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request strobe; sampled only in IDLE and DONE.
- dividend  in  8  unsigned fraction 0.dddddddd.
- divisor  in  8  unsigned fraction; must be normalized (bit 7 = 1).
- busy  out  1  high from the cycle after start is accepted until DONE is entered.
- done  out  1  one-cycle pulse; quotient and err valid in that cycle.
- quotient  out  4*ITER  result, held until the next accepted start.
- err  out  1  operand-range error for the operation just completed.
- dp_op1  out  8  to divider op1 (captured dividend).
- dp_op2  out  8  to divider op2 (captured divisor).
- dp_state0  out  1  to divider state0; 1 means load/initialize residual.
- dp_qj  in  4  positive quotient-digit vector from the divider.
- dp_qjn  in  4  negative quotient-digit vector from the divider.
- dp_sum2  in  11  stage-2 residual sum.
- dp_carry2  in  11  stage-2 residual carry.

## Operation
- States: IDLE, LOAD, ITER, CORR, DONE. Reset forces IDLE.
- IDLE or DONE with start=1:
  - Capture dividend and divisor into the op registers.
  - If divisor[7]=0 or dividend >= divisor, go to DONE with err=1 and quotient all ones.
  - Otherwise clear Qp, Qn and err, and go to LOAD.
- IDLE or DONE with start=0: go to IDLE.
- LOAD (1 cycle):
  - dp_state0=1.
  - Load the iteration counter with ITER-1.
  - Go to ITER.
- ITER (ITER cycles):
  - dp_state0=0.
  - On each edge: Qp <= {Qp[4*ITER-5:0], dp_qj} and Qn <= {Qn[4*ITER-5:0], dp_qjn}.
  - Decrement the counter. When the counter is 0, go to CORR.
- CORR (1 cycle):
  - rem_neg = bit 10 of (dp_sum2 + dp_carry2), 11-bit modulo add.
  - quotient <= Qp - Qn - rem_neg, modulo 2^(4*ITER).
  - Go to DONE.
- DONE (1 cycle): done=1, then start handling as above.
- start in LOAD, ITER or CORR is ignored; no queuing.
- dp_op1/dp_op2 are driven only from the op registers. They are stable from LOAD through CORR.
- Arithmetic:
  - Digit value is qj - qjn (range -15..+15).
  - Qp/Qn subtraction and the correction decrement both wrap modulo 2^(4*ITER).
  - For in-range operands the result equals floor(dividend*2^(4*ITER)/divisor).

## Timing
- Reset values:
  - quotient=0, err=0, busy=0, done=0.
  - dp_state0=0, dp_op1=0, dp_op2=0.
  - Qp=Qn=0, counter=0, state IDLE.
- Latency, start sampled high at edge 0 (valid operands):
  - LOAD in cycle 1.
  - ITER in cycles 2..ITER+1.
  - CORR in cycle ITER+2.
  - done=1 in cycle ITER+3. With ITER=2, done follows 5 edges after start.
- Error path: done=1 in cycle 1 with err=1. The datapath is never loaded.
- busy=1 in cycles 1..ITER+2. busy=0 in DONE and IDLE.
- Back-to-back: start high during DONE is accepted. LOAD follows immediately, so done pulses are ITER+3 cycles apart.
- Reset asserted mid-operation:
  - Immediately (asynchronously) returns to IDLE with all reset values.
  - The partial result is discarded and no done pulse occurs.
- Reset is released synchronously to clock by the system; start is ignored while reset=1.

## Test plan
- Normal divide, ITER=2, 0xAF / 0xC5 -> done 5 cycles after start, quotient=0xE3, err=0; dp_state0 high for exactly one cycle.
- Exact divide, 0x93 / 0xC0 -> quotient=0xC4, err=0. Then 0x60 / 0xC0 -> quotient=0x80; rem_neg must not decrement an exact result.
- Range errors:
  - 0x80 / 0x80 -> done in cycle 1, err=1, quotient=0xFF, dp_state0 never high.
  - 0x10 / 0x40 (unnormalized) -> same error response.
- start held high continuously with 0xAF/0xC5 -> done pulses every 5 cycles with quotient=0xE3 each time; starts during busy are not counted.
- Reset asserted in the first ITER cycle of 0xAF/0xC5 -> all outputs return to reset values at once, no done pulse. A following 0x93/0xC0 request gives 0xC4.
- Bench digit model driving dp_qj/dp_qjn for digits +15 then -15 with positive remainder -> quotient = 0xF0 - 0x0F = 0xE1. Same digits with negative remainder -> 0xE0.
